// File: rtl/vc_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_pipe_pkg
// Description : Shared constants and helpers for the elastic pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
package vc_pipe_pkg;

    localparam int c_DEF_NBITS = 32;
    localparam int c_DEF_DEPTH = 2;

    // Occupancy runs 0..depth inclusive, so it needs depth+1 codes.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_elastic_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : vc_elastic_pipe_reg_if
// Description : val/rdy producer and consumer bundle plus flush and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface vc_elastic_pipe_reg_if
    import vc_pipe_pkg::*;
#(
    parameter int P_NBITS = c_DEF_NBITS,
    parameter int P_DEPTH = c_DEF_DEPTH
);

    localparam int c_CNT_W = cnt_width(P_DEPTH);

    logic               in_val;
    logic               in_rdy;
    logic [P_NBITS-1:0] in_msg;
    logic               out_val;
    logic               out_rdy;
    logic [P_NBITS-1:0] out_msg;
    logic               flush;
    logic [c_CNT_W-1:0] count;

    modport master (
        output in_val,
        output in_msg,
        output out_rdy,
        output flush,
        input  in_rdy,
        input  out_val,
        input  out_msg,
        input  count
    );

    modport slave (
        input  in_val,
        input  in_msg,
        input  out_rdy,
        input  flush,
        output in_rdy,
        output out_val,
        output out_msg,
        output count
    );

endinterface
`default_nettype wire

// File: rtl/vc_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : vc_pipe_stage
// Description : One valid+data register pair of the elastic pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_pipe_stage
    import vc_pipe_pkg::*;
#(
    parameter int                 P_NBITS       = c_DEF_NBITS,
    parameter logic [P_NBITS-1:0] P_RESET_VALUE = '0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               i_go,
    input  wire logic               i_flush,
    input  wire logic               i_src_val,
    input  wire logic [P_NBITS-1:0] i_src_data,
    output logic                    o_val,
    output logic [P_NBITS-1:0]      o_data
);

    logic               r_val;
    logic [P_NBITS-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val  <= 1'b0;
            r_data <= P_RESET_VALUE;
        end else if (i_flush) begin
            // Flush drops validity only; the stale data is harmless once invalid.
            r_val  <= 1'b0;
        end else if (i_go) begin
            r_val <= i_src_val;
            if (i_src_val) begin
                r_data <= i_src_data;
            end
        end
    end

    assign o_val  = r_val;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/vc_elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : vc_elastic_pipe_reg
// Description : P_DEPTH-stage val/rdy pipeline register with bubble collapsing,
//               backpressure, synchronous flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_elastic_pipe_reg
    import vc_pipe_pkg::*;
#(
    parameter int                 P_NBITS       = c_DEF_NBITS,
    parameter int                 P_DEPTH       = c_DEF_DEPTH,
    parameter logic [P_NBITS-1:0] P_RESET_VALUE = '0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    vc_elastic_pipe_reg_if.slave   pif
);

    localparam int c_CNT_W = cnt_width(P_DEPTH);

    typedef struct packed {
        logic               val;
        logic [P_NBITS-1:0] data;
    } stage_t;

    logic [P_DEPTH-1:0] w_val;
    logic [P_NBITS-1:0] w_data [P_DEPTH];
    logic [P_DEPTH-1:0] w_go;
    stage_t             w_src  [P_DEPTH];
    logic               w_in_rdy;
    logic [c_CNT_W-1:0] w_count;

    // Ready ripples combinationally from the output back to the input stage.
    assign w_go[P_DEPTH-1] = !w_val[P_DEPTH-1] || pif.out_rdy;

    for (genvar gi = 0; gi < P_DEPTH - 1; gi++) begin : g_go
        assign w_go[gi] = !w_val[gi] || w_go[gi+1];
    end

    assign w_in_rdy = w_go[0] && !pif.flush && !reset;

    for (genvar gi = 0; gi < P_DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_src[gi] = '{val: pif.in_val && w_in_rdy, data: pif.in_msg};
        end else begin : g_body
            assign w_src[gi] = '{val: w_val[gi-1], data: w_data[gi-1]};
        end

        vc_pipe_stage #(
            .P_NBITS       (P_NBITS),
            .P_RESET_VALUE (P_RESET_VALUE)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .i_go       (w_go[gi]),
            .i_flush    (pif.flush),
            .i_src_val  (w_src[gi].val),
            .i_src_data (w_src[gi].data),
            .o_val      (w_val[gi]),
            .o_data     (w_data[gi])
        );
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            w_count = w_count + c_CNT_W'(w_val[i]);
        end
    end

    assign pif.in_rdy  = w_in_rdy;
    assign pif.out_val = w_val[P_DEPTH-1];
    assign pif.out_msg = w_data[P_DEPTH-1];
    assign pif.count   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_vc_elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_elastic_pipe_reg
// Description : Directed self-checking bench over depths 1, 2, 3 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_elastic_pipe_reg;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    logic       mval;
    logic [7:0] mdata;
    logic       iv;
    logic       ordy;
    logic       exp_rdy;

    vc_elastic_pipe_reg_if #(.P_NBITS(8), .P_DEPTH(3)) if3 ();
    vc_elastic_pipe_reg_if #(.P_NBITS(8), .P_DEPTH(4)) if4 ();
    vc_elastic_pipe_reg_if #(.P_NBITS(8), .P_DEPTH(2)) if2 ();
    vc_elastic_pipe_reg_if #(.P_NBITS(8), .P_DEPTH(1)) if1 ();

    vc_elastic_pipe_reg #(.P_NBITS(8), .P_DEPTH(3), .P_RESET_VALUE(8'h00))
        u3 (.clk(clk), .reset(reset), .pif(if3.slave));
    vc_elastic_pipe_reg #(.P_NBITS(8), .P_DEPTH(4), .P_RESET_VALUE(8'h00))
        u4 (.clk(clk), .reset(reset), .pif(if4.slave));
    vc_elastic_pipe_reg #(.P_NBITS(8), .P_DEPTH(2), .P_RESET_VALUE(8'h00))
        u2 (.clk(clk), .reset(reset), .pif(if2.slave));
    vc_elastic_pipe_reg #(.P_NBITS(8), .P_DEPTH(1), .P_RESET_VALUE(8'hEE))
        u1 (.clk(clk), .reset(reset), .pif(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control inputs must never be X outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            n_assert++;
            assert (!$isunknown({if3.in_val, if3.out_rdy, if3.flush, if4.in_val, if4.out_rdy,
                                 if4.flush, if2.in_val, if2.out_rdy, if2.flush,
                                 if1.in_val, if1.out_rdy, if1.flush}))
            else begin
                n_fail++;
                $error("FAIL xcheck: observed X on control inputs expected known");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mval     = 1'b0;
        mdata    = '0;
        reset    = 1'b1;
        if3.in_val = 0; if3.in_msg = '0; if3.out_rdy = 0; if3.flush = 0;
        if4.in_val = 0; if4.in_msg = '0; if4.out_rdy = 0; if4.flush = 0;
        if2.in_val = 0; if2.in_msg = '0; if2.out_rdy = 0; if2.flush = 0;
        if1.in_val = 0; if1.in_msg = '0; if1.out_rdy = 0; if1.flush = 0;

        // Reset state
        tick(); tick();
        chk("rst_in_rdy",   32'(if3.in_rdy),  32'd0);
        chk("rst_out_val",  32'(if3.out_val), 32'd0);
        chk("rst_count",    32'(if3.count),   32'd0);
        chk("rst_out_msg",  32'(if3.out_msg), 32'h00);
        chk("rst_value_d1", 32'(if1.out_msg), 32'hEE);
        reset = 1'b0;
        #1;
        chk("deassert_rdy", 32'(if3.in_rdy), 32'd1);
        tick();
        chk("first_edge_rdy",   32'(if3.in_rdy), 32'd1);
        chk("first_edge_count", 32'(if3.count),  32'd0);

        // Reset mid-stream, depth 3
        if3.in_val = 1; if3.in_msg = 8'h0A; tick();
        if3.in_msg = 8'h0B; tick();
        if3.in_msg = 8'h0C; tick();
        if3.in_val = 0;
        #1;
        chk("full3_count",   32'(if3.count),   32'd3);
        chk("full3_out_val", 32'(if3.out_val), 32'd1);
        chk("full3_out_msg", 32'(if3.out_msg), 32'h0A);
        chk("full3_in_rdy",  32'(if3.in_rdy),  32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_out_val", 32'(if3.out_val), 32'd0);
        chk("midrst_count",   32'(if3.count),   32'd0);
        chk("midrst_out_msg", 32'(if3.out_msg), 32'h00);
        chk("midrst_in_rdy",  32'(if3.in_rdy),  32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("postrst_in_rdy", 32'(if3.in_rdy), 32'd1);
        tick();
        chk("postrst_count",   32'(if3.count),   32'd0);
        chk("postrst_out_val", 32'(if3.out_val), 32'd0);

        // Latency and throughput, depth 3
        if3.out_rdy = 1;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                if3.in_val = 1;
                if3.in_msg = 8'(k + 1);
            end else begin
                if3.in_val = 0;
            end
            #1;
            if (k < 8) chk($sformatf("lat_in_rdy_%0d", k), 32'(if3.in_rdy), 32'd1);
            if (k >= 3 && k <= 10) begin
                chk($sformatf("lat_out_val_%0d", k), 32'(if3.out_val), 32'd1);
                chk($sformatf("lat_out_msg_%0d", k), 32'(if3.out_msg), 32'(k - 2));
            end else begin
                chk($sformatf("lat_idle_%0d", k), 32'(if3.out_val), 32'd0);
            end
            tick();
        end
        if3.out_rdy = 0;

        // Backpressure and bubble collapse, depth 4
        if4.in_val = 1; if4.in_msg = 8'h11; tick();
        if4.in_val = 0; tick();
        if4.in_val = 1; if4.in_msg = 8'h22; tick();
        if4.in_val = 0;
        #1;
        chk("bp_count_2",   32'(if4.count),   32'd2);
        chk("bp_out_val_0", 32'(if4.out_val), 32'd0);
        tick();
        chk("bp_head_val", 32'(if4.out_val), 32'd1);
        chk("bp_head_msg", 32'(if4.out_msg), 32'h11);
        tick(); tick(); tick();
        chk("bp_hold_msg",   32'(if4.out_msg), 32'h11);
        chk("bp_hold_count", 32'(if4.count),   32'd2);
        chk("bp_hold_rdy",   32'(if4.in_rdy),  32'd1);
        if4.out_rdy = 1;
        #1;
        chk("bp_rel_msg0", 32'(if4.out_msg), 32'h11);
        tick();
        chk("bp_rel_val1",   32'(if4.out_val), 32'd1);
        chk("bp_rel_msg1",   32'(if4.out_msg), 32'h22);
        chk("bp_rel_count1", 32'(if4.count),   32'd1);
        tick();
        chk("bp_rel_empty", 32'(if4.out_val), 32'd0);
        chk("bp_rel_count", 32'(if4.count),   32'd0);
        if4.out_rdy = 0;

        // Full pipe with simultaneous in/out, depth 2
        if2.in_val = 1; if2.in_msg = 8'h05; tick();
        if2.in_msg = 8'h06;
        #1;
        chk("d2_fill_rdy", 32'(if2.in_rdy), 32'd1);
        tick();
        if2.in_msg = 8'h07;
        #1;
        chk("d2_full_stall_rdy", 32'(if2.in_rdy), 32'd0);
        chk("d2_full_count",     32'(if2.count),  32'd2);
        if2.out_rdy = 1;
        #1;
        chk("d2_full_pass_rdy", 32'(if2.in_rdy),  32'd1);
        chk("d2_full_msg5",     32'(if2.out_msg), 32'h05);
        tick();
        if2.in_val = 0;
        #1;
        chk("d2_count_kept", 32'(if2.count),   32'd2);
        chk("d2_msg6",       32'(if2.out_msg), 32'h06);
        tick();
        chk("d2_msg7",   32'(if2.out_msg), 32'h07);
        chk("d2_count1", 32'(if2.count),   32'd1);
        tick();
        chk("d2_empty", 32'(if2.out_val), 32'd0);
        if2.out_rdy = 0;

        // Flush, depth 3
        if3.in_val = 1; if3.in_msg = 8'h31; tick();
        if3.in_msg = 8'h32; tick();
        if3.in_msg = 8'h33; tick();
        if3.in_msg = 8'h34; if3.out_rdy = 1; if3.flush = 1;
        #1;
        chk("fl_in_rdy",  32'(if3.in_rdy),  32'd0);
        chk("fl_out_val", 32'(if3.out_val), 32'd1);
        chk("fl_out_msg", 32'(if3.out_msg), 32'h31);
        chk("fl_count",   32'(if3.count),   32'd3);
        tick();
        if3.flush = 0; if3.in_val = 0;
        #1;
        chk("fl_after_count", 32'(if3.count),   32'd0);
        chk("fl_after_val",   32'(if3.out_val), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_no_stale_%0d", k), 32'(if3.out_val), 32'd0);
        end
        if3.in_val = 1; if3.in_msg = 8'h35;
        #1;
        chk("fl_refill_rdy", 32'(if3.in_rdy), 32'd1);
        tick();
        if3.in_val = 0;
        tick(); tick();
        chk("fl_refill_val", 32'(if3.out_val), 32'd1);
        chk("fl_refill_msg", 32'(if3.out_msg), 32'h35);
        tick();
        chk("fl_refill_gone", 32'(if3.out_val), 32'd0);
        if3.out_rdy = 0;

        // Depth-1 corner with a one-entry reference model
        for (int k = 0; k < 16; k++) begin
            iv   = 1'(k & 1) ^ 1'((k >> 2) & 1);
            ordy = 1'((k >> 1) & 1) | 1'((k >> 3) & 1);
            if1.in_val  = iv;
            if1.in_msg  = 8'(8'h40 + k);
            if1.out_rdy = ordy;
            #1;
            exp_rdy = !mval || ordy;
            chk($sformatf("d1_rdy_%0d", k), 32'(if1.in_rdy),  32'(exp_rdy));
            chk($sformatf("d1_val_%0d", k), 32'(if1.out_val), 32'(mval));
            if (mval) chk($sformatf("d1_msg_%0d", k), 32'(if1.out_msg), 32'(mdata));
            if (iv && exp_rdy) begin
                mval  = 1'b1;
                mdata = 8'(8'h40 + k);
            end else if (mval && ordy) begin
                mval = 1'b0;
            end
            tick();
        end
        if1.in_val  = 0;
        if1.out_rdy = 1;
        #1;
        chk("d1_drain_val", 32'(if1.out_val), 32'(mval));
        if (mval) chk("d1_drain_msg", 32'(if1.out_msg), 32'(mdata));
        tick();
        chk("d1_drain_empty", 32'(if1.out_val), 32'd0);
        if1.out_rdy = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
